// File: rtl/aes_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : aes_bus_sequencer_if
// Brief  : Request/result handshake and AES core register bus bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface aes_bus_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_plain;
    logic [255:0] in_key;
    logic         in_keyld;
    logic [7:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_err;
    logic [6:0]   addr;
    logic [7:0]   din;
    logic         wr;
    logic         start;
    logic         ok;
    logic [7:0]   dout;

    // Sequencer view
    modport slave (
        input  in_valid, in_plain, in_key, in_keyld, in_mode, out_ready, ok, dout,
        output in_ready, out_valid, out_data, out_err, addr, din, wr, start
    );

    // Host plus core view
    modport master (
        output in_valid, in_plain, in_key, in_keyld, in_mode, out_ready, ok, dout,
        input  in_ready, out_valid, out_data, out_err, addr, din, wr, start
    );
endinterface
`default_nettype wire

// File: rtl/aes_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module : aes_bus_sequencer
// Brief  : Loads block/key into the AES core byte bus, starts it, reads result.
// Rev    : 1.0  initial release
// ============================================================================
module aes_bus_sequencer #(
    parameter int OK_TIMEOUT = 1023
) (
    input  wire                 clk,
    input  wire                 rst,
    aes_bus_sequencer_if.slave  bus
);
    localparam int TW = (OK_TIMEOUT < 2) ? 1 : $clog2(OK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_PT   = 4'd1,
        S_WR_KEY  = 4'd2,
        S_WR_CTL  = 4'd3,
        S_GO      = 4'd4,
        S_WAIT_OK = 4'd5,
        S_READ    = 4'd6,
        S_OUT     = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t         r_state;
    logic [5:0]     r_cnt;
    logic [TW-1:0]  r_timer;
    logic [127:0]   r_plain;
    logic [255:0]   r_key;
    logic           r_keyld;
    logic [7:0]     r_mode;
    logic [6:0]     r_addr;
    logic [7:0]     r_din;
    logic           r_wr;
    logic           r_start;
    logic           r_out_valid;
    logic           r_out_err;
    logic [127:0]   r_out_data;

    logic [5:0]     w_nxt;
    logic [3:0]     w_rd_idx;
    logic [7:0]     w_pt_byte;
    logic [7:0]     w_key_byte;

    // Bus outputs are registered one cycle ahead, so byte selects use cnt+1.
    assign w_nxt      = r_cnt + 6'd1;
    assign w_rd_idx   = r_cnt[3:0] - 4'd1;
    assign w_pt_byte  = r_plain[{w_nxt[3:0], 3'b000} +: 8];
    assign w_key_byte = r_key[{w_nxt[4:0], 3'b000} +: 8];

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.addr      = r_addr;
    assign bus.din       = r_din;
    assign bus.wr        = r_wr;
    assign bus.start     = r_start;
    assign bus.out_valid = r_out_valid;
    assign bus.out_err   = r_out_err;
    assign bus.out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_wr        <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_plain    <= bus.in_plain;
                        r_key      <= bus.in_key;
                        r_keyld    <= bus.in_keyld;
                        r_mode     <= bus.in_mode;
                        r_cnt      <= '0;
                        r_wr       <= 1'b1;
                        r_addr     <= 7'd0;
                        r_din      <= bus.in_plain[7:0];
                        r_out_data <= '0;
                        r_state    <= S_WR_PT;
                    end
                end
                S_WR_PT: begin
                    if (r_cnt == 6'd15) begin
                        r_cnt <= '0;
                        if (r_keyld) begin
                            r_addr  <= 7'd32;
                            r_din   <= r_key[7:0];
                            r_state <= S_WR_KEY;
                        end else begin
                            r_addr  <= 7'd64;
                            r_din   <= 8'h00;
                            r_state <= S_WR_CTL;
                        end
                    end else begin
                        r_cnt  <= w_nxt;
                        r_addr <= {3'b000, w_nxt[3:0]};
                        r_din  <= w_pt_byte;
                    end
                end
                S_WR_KEY: begin
                    if (r_cnt == 6'd31) begin
                        r_cnt   <= '0;
                        r_addr  <= 7'd64;
                        r_din   <= 8'h00;
                        r_state <= S_WR_CTL;
                    end else begin
                        r_cnt  <= w_nxt;
                        r_addr <= 7'd32 + {2'b00, w_nxt[4:0]};
                        r_din  <= w_key_byte;
                    end
                end
                S_WR_CTL: begin
                    if (r_cnt == 6'd0) begin
                        r_cnt  <= 6'd1;
                        r_addr <= 7'd65;
                        r_din  <= r_mode;
                    end else begin
                        r_wr    <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= S_GO;
                    end
                end
                S_GO: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_OK;
                end
                S_WAIT_OK: begin
                    // OK takes priority over an expiring timer in the same cycle.
                    if (bus.ok) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_addr  <= 7'd16;
                        r_state <= S_READ;
                    end else if (r_timer == TW'(OK_TIMEOUT - 1)) begin
                        r_start     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_data  <= '0;
                        r_state     <= S_ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_READ: begin
                    if (!bus.ok) begin
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_data  <= '0;
                        r_state     <= S_ERR;
                    end else begin
                        // DOUT lags ADDR by one cycle: cycle n+1 carries byte n.
                        if (r_cnt != 6'd0) begin
                            r_out_data[{w_rd_idx, 3'b000} +: 8] <= bus.dout;
                        end
                        if (r_cnt == 6'd16) begin
                            r_out_valid <= 1'b1;
                            r_out_err   <= 1'b0;
                            r_state     <= S_OUT;
                        end else begin
                            r_cnt  <= w_nxt;
                            r_addr <= 7'd16 + {1'b0, w_nxt};
                        end
                    end
                end
                S_OUT, S_ERR: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_bus_sequencer
// Brief  : Randomized bench with a behavioural AES-core stand-in and model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aes_bus_sequencer;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    logic [7:0]  dmask = 8'hA5;
    int          ok_delay = 0;
    bit          drop_en = 1'b0;
    int          scnt = 0;
    logic [15:0] wq[$];

    aes_bus_sequencer_if bus_if ();

    aes_bus_sequencer #(.OK_TIMEOUT(T)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Core stand-in: registered DOUT, OK a fixed number of START cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus_if.dout <= {1'b0, bus_if.addr} ^ dmask;
        if (rst) begin
            bus_if.ok <= 1'b0;
            scnt      <= 0;
        end else begin
            if (bus_if.in_valid && bus_if.in_ready) begin
                acc_cyc   <= cyc + 1;
                bus_if.ok <= 1'b0;
                scnt      <= 0;
            end else if (bus_if.start) begin
                scnt <= scnt + 1;
                if (ok_delay != 0 && scnt + 1 == ok_delay) bus_if.ok <= 1'b1;
            end
            if (drop_en && bus_if.ok && !bus_if.wr && !bus_if.start && bus_if.addr == 7'd23)
                bus_if.ok <= 1'b0;
            if (bus_if.wr) wq.push_back({1'b0, bus_if.addr, bus_if.din});
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] p, input logic [255:0] k, input bit kl,
                        input logic [7:0] m);
        int n;
        @(negedge clk);
        wq.delete();
        bus_if.in_plain = p;
        bus_if.in_key   = k;
        bus_if.in_keyld = kl;
        bus_if.in_mode  = m;
        bus_if.in_valid = 1'b1;
        n = 0;
        while (!bus_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", {127'd0, bus_if.in_ready}, 128'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.in_plain = {$urandom, $urandom, $urandom, $urandom};
        bus_if.in_key   = {8{$urandom}};
        bus_if.in_keyld = 1'($urandom);
        bus_if.in_mode  = 8'($urandom);
    endtask

    task automatic run_txn(input logic [127:0] p, input logic [255:0] k, input bit kl,
                           input logic [7:0] m, input logic [7:0] mask, input int dly,
                           input bit drop, input int hold);
        int          n;
        bit          rdy_seen;
        bit          exp_err;
        logic [15:0] exp_w[$];
        logic [127:0] exp_d;
        logic [127:0] held;
        logic [7:0]  a;
        int          lat;
        dmask    = mask;
        ok_delay = dly;
        drop_en  = drop;
        bus_if.out_ready = 1'b0;
        send(p, k, kl, m);
        n = 0;
        rdy_seen = 1'b0;
        while (!bus_if.out_valid && n < 3000) begin
            if (bus_if.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", {127'd0, bus_if.out_valid}, 128'd1);
        check("in_ready_busy", {127'd0, rdy_seen}, 128'd0);

        for (int i = 0; i < 16; i++) exp_w.push_back({1'b0, 7'(i), p[8*i +: 8]});
        if (kl) for (int i = 0; i < 32; i++) exp_w.push_back({1'b0, 7'(32 + i), k[8*i +: 8]});
        exp_w.push_back({1'b0, 7'd64, 8'h00});
        exp_w.push_back({1'b0, 7'd65, m});
        check("write_count", 128'(wq.size()), 128'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            if (i < wq.size()) check($sformatf("write%0d", i), 128'(wq[i]), 128'(exp_w[i]));

        exp_err = (dly == 0) || drop;
        for (int j = 0; j < 16; j++) begin
            a = 8'(16 + j);
            exp_d[8*j +: 8] = a ^ mask;
        end
        if (exp_err) exp_d = '0;
        check("out_err", {127'd0, bus_if.out_err}, {127'd0, exp_err});
        check("out_data", bus_if.out_data, exp_d);
        check("start_low", {127'd0, bus_if.start}, 128'd0);
        if (!drop) begin
            lat = 16 + (kl ? 32 : 0) + 2 + 1 + ((dly == 0) ? T : dly + 17);
            check("latency", 128'(cyc - acc_cyc), 128'(lat));
        end

        held = bus_if.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {127'd0, bus_if.out_valid}, 128'd1);
            check("hold_data", bus_if.out_data, held);
            check("hold_in_ready", {127'd0, bus_if.in_ready}, 128'd0);
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("post_valid", {127'd0, bus_if.out_valid}, 128'd0);
        check("post_in_ready", {127'd0, bus_if.in_ready}, 128'd1);
    endtask

    task automatic reset_midrun(input int wait_cyc);
        bit seen;
        ok_delay = 5;
        drop_en  = 1'b0;
        bus_if.out_ready = 1'b1;
        send({4{$urandom}}, {8{$urandom}}, 1'b1, 8'h11);
        repeat (wait_cyc) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wr", {127'd0, bus_if.wr}, 128'd0);
        check("rst_start", {127'd0, bus_if.start}, 128'd0);
        check("rst_addr_din", {113'd0, bus_if.addr, bus_if.din}, 128'd0);
        check("rst_out", {bus_if.out_data[126:0], bus_if.out_valid} | {127'd0, bus_if.out_err}, 128'd0);
        repeat (2) begin
            check("rst_in_ready", {127'd0, bus_if.in_ready}, 128'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", {127'd0, bus_if.in_ready}, 128'd1);
        seen = 1'b0;
        repeat (150) begin
            if (bus_if.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("no_out_after_rst", {127'd0, seen}, 128'd0);
        bus_if.out_ready = 1'b0;
    endtask

    logic [127:0] c_pt;
    logic [255:0] c_key;

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_plain  = '0;
        bus_if.in_key    = '0;
        bus_if.in_keyld  = 1'b0;
        bus_if.in_mode   = '0;
        bus_if.out_ready = 1'b0;
        c_pt = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        for (int i = 0; i < 32; i++) c_key[8*i +: 8] = 8'(i);

        repeat (3) @(negedge clk);
        check("reset_in_ready", {127'd0, bus_if.in_ready}, 128'd0);
        check("reset_outs", {bus_if.out_data[126:0], bus_if.out_valid}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {127'd0, bus_if.in_ready}, 128'd1);

        run_txn(c_pt, c_key, 1'b1, 8'h05, 8'hA5, 20, 1'b0, 0);
        run_txn(c_pt, c_key, 1'b0, 8'h05, 8'hA5, 20, 1'b0, 0);
        run_txn(c_pt, c_key, 1'b1, 8'h05, 8'hA5, 0, 1'b0, 2);
        run_txn(c_pt, c_key, 1'b0, 8'h09, 8'h3C, 7, 1'b0, 10);
        run_txn(c_pt, c_key, 1'b1, 8'h05, 8'hA5, 20, 1'b1, 1);
        reset_midrun(25);
        reset_midrun(2);

        for (int r = 0; r < 6; r++)
            run_txn({$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
                    1'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 40)), 1'b0, int'($urandom_range(0, 3)));
        run_txn({4{$urandom}}, {8{$urandom}}, 1'b0, 8'h77, 8'h00, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
